// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Instructions are word aligned; redirect targets lose their low two bits.
  localparam logic [XLEN_DEFAULT-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int PC_INCR = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC owner, single-outstanding imem fetch, decode buffer  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(~INSTR_ALIGN_MASK);
  localparam logic [XLEN-1:0] C_PC_INCR    = XLEN'(PC_INCR);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & C_ALIGN_MASK;

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          r_state <= REQ;
        end
        // The request has already gone out, so a redirect must wait for its response.
        REQ: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= DROP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + C_PC_INCR;
            r_state    <= HOLD;
          end
        end
        DROP: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          if (imem_rvalid)    r_state <= REQ;
        end
        // Redirect wins over the handshake: the held word is squashed, not consumed.
        HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= REQ;
          end else if (instr_ready) begin
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_rvalid_protocol : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_state == WAIT || r_state == DROP));

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench for fetch_unit             |
// | Revision      : 1.0 - initial release                                |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_instr_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic        sel = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_instr, a_pc, b_addr, b_instr, b_pc;
  logic        m_req, m_valid, m_rst;
  logic [31:0] m_addr, m_instr, m_pc;

  logic [31:0] exp_req[$];
  exp_instr_t  exp_ins[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst_n(rst_a),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(a_valid), .instr_ready(instr_ready),
    .instr(a_instr), .instr_pc(a_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst_n(rst_b),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(b_valid), .instr_ready(instr_ready),
    .instr(b_instr), .instr_pc(b_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  assign m_req   = sel ? b_req   : a_req;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_instr = sel ? b_instr : a_instr;
  assign m_pc    = sel ? b_pc    : a_pc;
  assign m_rst   = sel ? rst_b   : rst_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!m_valid && k < max) begin
      tick();
      k++;
    end
    if (!m_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: instr_valid not seen within %0d cycles", max);
    end
  endtask

  // Memory model: answers each request after 'lat' cycles; quiet while in reset.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!m_rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
      if (m_req) begin
        cnt       = lat;
        pend_addr = m_addr;
      end
    end
  end

  // Scoreboard monitor: every request and every accepted instruction must be expected.
  always @(negedge clk) begin
    exp_instr_t e;
    if (m_req) begin
      if (exp_req.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got addr %h, expected no request", m_addr);
      end else begin
        check("req_addr", m_addr, exp_req.pop_front());
      end
    end
    if (m_valid && instr_ready && !redirect_valid) begin
      if (exp_ins.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got %h @ %h, expected none", m_instr, m_pc);
      end else begin
        e = exp_ins.pop_front();
        check("instr_word", m_instr, e.instr);
        check("instr_pc", m_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_req.push_back(32'h0000_0000);
    exp_req.push_back(32'h0000_0004);
    exp_req.push_back(32'h0000_0008);
    exp_req.push_back(32'h0000_0040);
    exp_req.push_back(32'h0000_0100);
    exp_req.push_back(32'h0000_0200);
    exp_ins.push_back('{instr: 32'h0050_0093, pc: 32'h0000_0000});
    exp_ins.push_back('{instr: 32'h0000_0413, pc: 32'h0000_0004});

    #1;
    check("rst_req", {31'b0, m_req}, 32'h0);
    check("rst_valid", {31'b0, m_valid}, 32'h0);
    check("rst_instr", m_instr, 32'h0);
    check("rst_instr_pc", m_pc, 32'h0);
    check("rst_addr", m_addr, 32'h0);

    // Basic fetch with 1-cycle memory.
    tick();
    tick();
    rst_a = 1'b1;
    tick();
    check("c1_req", {31'b0, m_req}, 32'h1);
    check("c1_addr", m_addr, 32'h0);
    tick();
    check("c2_valid", {31'b0, m_valid}, 32'h0);
    tick();
    check("c3_valid", {31'b0, m_valid}, 32'h1);
    check("c3_instr", m_instr, 32'h0050_0093);
    check("c3_pc", m_pc, 32'h0);
    tick();
    check("c4_addr", m_addr, 32'h4);
    instr_ready = 1'b0;

    // Back-pressure for 5 cycles.
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", m_instr, 32'h0000_0413);
      check("bp_pc", m_pc, 32'h4);
      check("bp_req", {31'b0, m_req}, 32'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_next_addr", m_addr, 32'h8);

    // Redirect together with ready in HOLD at pc 8.
    wait_valid(10);
    check("h8_pc", m_pc, 32'h8);
    check("h8_instr", m_instr, 32'h0000_0813);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    lat = 3;
    check("rh_req", {31'b0, m_req}, 32'h1);
    check("rh_addr", m_addr, 32'h40);
    check("rh_valid", {31'b0, m_valid}, 32'h0);

    // Redirect in WAIT, stale response two cycles later.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    check("rw_drop_valid", {31'b0, m_valid}, 32'h0);
    check("rw_drop_req", {31'b0, m_req}, 32'h0);
    check("rw_aligned_pc", m_addr, 32'h100);
    tick();
    check("rw_drop2_valid", {31'b0, m_valid}, 32'h0);
    tick();
    check("rw_req", {31'b0, m_req}, 32'h1);
    check("rw_addr", m_addr, 32'h100);
    check("rw_valid", {31'b0, m_valid}, 32'h0);

    // Redirect coinciding with the response in WAIT.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("rr_req", {31'b0, m_req}, 32'h1);
    check("rr_addr", m_addr, 32'h200);
    check("rr_valid", {31'b0, m_valid}, 32'h0);
    wait_valid(10);
    check("rr_instr", m_instr, 32'h0002_0013);
    check("rr_pc", m_pc, 32'h200);
    #2;
    rst_a = 1'b0;
    #1;
    check("a_async_valid", {31'b0, m_valid}, 32'h0);
    check("a_async_instr", m_instr, 32'h0);

    // Second instance: RESET_PC at the top of the address space.
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_ins.push_back('{instr: 32'hFFFF_FC13, pc: 32'hFFFF_FFFC});
    sel = 1'b1;
    instr_ready = 1'b1;
    tick();
    rst_b = 1'b1;
    tick();
    check("b_req", {31'b0, m_req}, 32'h1);
    check("b_addr", m_addr, 32'hFFFF_FFFC);
    tick();
    lat = 4;
    tick();
    check("b_valid", {31'b0, m_valid}, 32'h1);
    check("b_instr", m_instr, 32'hFFFF_FC13);
    check("b_pc", m_pc, 32'hFFFF_FFFC);
    tick();
    check("b_wrap_addr", m_addr, 32'h0);
    tick();
    check("b_wait_pc", m_pc, 32'hFFFF_FFFC);
    #2;
    rst_b = 1'b0;
    #1;
    check("b_async_req", {31'b0, m_req}, 32'h0);
    check("b_async_valid", {31'b0, m_valid}, 32'h0);
    check("b_async_instr", m_instr, 32'h0);
    check("b_async_pc", m_pc, 32'h0);
    check("b_async_addr", m_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("b_held_req", {31'b0, m_req}, 32'h0);

    check("left_req", exp_req.size(), 32'h0);
    check("left_instr", exp_ins.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
